// File: rtl/draw_sequencer_if.sv
// Draw-engine scheduling bus: frame timing, client requests, engine
// ownership and the buffer-swap handshake with the display side.
interface draw_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic               frame_start;
  logic [NUM_REQ-1:0] req;
  logic               draw_done;
  logic               swap_ack;
  logic [NUM_REQ-1:0] grant;
  logic               draw_start;
  logic               swap_req;
  logic               frame_done;
  logic               busy;
  logic [7:0]         overrun_cnt;
  logic [NUM_REQ-1:0] timeout_err;

  // Sequencer side: owns grants and the swap handshake.
  modport master (
    input  frame_start, req, draw_done, swap_ack,
    output grant, draw_start, swap_req, frame_done, busy, overrun_cnt, timeout_err
  );

  // Environment side: frame timing, draw clients and display.
  modport slave (
    output frame_start, req, draw_done, swap_ack,
    input  grant, draw_start, swap_req, frame_done, busy, overrun_cnt, timeout_err
  );
endinterface

// File: rtl/draw_sequencer.sv
// Per-frame draw scheduler. On each frame tick the requesting clients are
// latched and serviced once each, lowest index (background layer) first,
// with a watchdog that force-releases a client that never reports done.
// After the last client the buffer swap is requested from the display side.
//
// state | meaning
// IDLE  | waiting for frame_start
// ARB   | picking the next pending client, or starting the swap
// WAIT  | a client owns the engine; watchdog running
// SWAP  | swap_req raised, waiting for swap_ack
module draw_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65536
) (
  input logic              Clk,
  input logic              RESET,
  draw_sequencer_if.master bus
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    WAIT = 2'd2,
    SWAP = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  pending, pending_nxt;
  logic [NUM_REQ-1:0]  grant_q, grant_nxt;
  logic [NUM_REQ-1:0]  tout_q, tout_nxt;
  logic [WDOG_W-1:0]   wdog, wdog_nxt;
  logic [7:0]          overrun_q, overrun_nxt;
  logic                draw_start_q, draw_start_nxt;
  logic                swap_req_q, swap_req_nxt;
  logic                frame_done_q, frame_done_nxt;
  logic [NUM_REQ-1:0]  low_pending;

  // Lowest set bit of pending: the bottom-most layer still to be drawn.
  assign low_pending = pending & (~pending + REQ_ONE);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt      = state;
    pending_nxt    = pending;
    grant_nxt      = grant_q;
    tout_nxt       = tout_q;
    wdog_nxt       = wdog;
    overrun_nxt    = overrun_q;
    draw_start_nxt = 1'b0;
    swap_req_nxt   = swap_req_q;
    frame_done_nxt = 1'b0;

    if (bus.frame_start && (state != IDLE) && (overrun_q != 8'hFF))
      overrun_nxt = overrun_q + 8'd1;

    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          pending_nxt = bus.req;
          state_nxt   = ARB;
        end
      end
      ARB: begin
        if (pending != '0) begin
          grant_nxt      = low_pending;
          draw_start_nxt = 1'b1;
          pending_nxt    = pending & ~low_pending;
          wdog_nxt       = '0;
          state_nxt      = WAIT;
        end else begin
          swap_req_nxt = 1'b1;
          state_nxt    = SWAP;
        end
      end
      WAIT: begin
        wdog_nxt = wdog + 1'b1;
        // A done arriving on the last watchdog cycle still counts as a clean finish.
        if (bus.draw_done) begin
          grant_nxt = '0;
          state_nxt = ARB;
        end else if (wdog == WDOG_LAST) begin
          tout_nxt  = tout_q | grant_q;
          grant_nxt = '0;
          state_nxt = ARB;
        end
      end
      SWAP: begin
        if (bus.swap_ack) begin
          swap_req_nxt   = 1'b0;
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset revokes any grant without flagging it.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state        <= IDLE;
      pending      <= '0;
      grant_q      <= '0;
      tout_q       <= '0;
      wdog         <= '0;
      overrun_q    <= '0;
      draw_start_q <= 1'b0;
      swap_req_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      grant_q      <= grant_nxt;
      tout_q       <= tout_nxt;
      wdog         <= wdog_nxt;
      overrun_q    <= overrun_nxt;
      draw_start_q <= draw_start_nxt;
      swap_req_q   <= swap_req_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.draw_start  = draw_start_q;
  assign bus.swap_req    = swap_req_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun_cnt = overrun_q;
  assign bus.timeout_err = tout_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: expected grant order is queued when a frame is
// started and popped whenever the DUT raises draw_start.
module tb_draw_sequencer;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic Clk = 1'b0;
  logic RESET;

  draw_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();

  draw_sequencer #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .Clk   (Clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NUM_REQ-1:0] exp_grant_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: each new grant must be the next expected client, one-hot.
  always @(negedge Clk) begin
    if (!RESET && bus.draw_start) begin
      check_val("grant_onehot", 32'($onehot(bus.grant)), 32'd1);
      if (exp_grant_q.size() == 0)
        check_val("grant_unexpected", 32'(bus.grant), 32'd0);
      else
        check_val("grant_order", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_frame(input logic [NUM_REQ-1:0] r);
    logic [NUM_REQ-1:0] oh;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r[i]) begin
        oh = '0;
        oh[i] = 1'b1;
        exp_grant_q.push_back(oh);
      end
    end
    bus.req = r;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic finish_draw();
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
  endtask

  // Called just after the edge where grant g rose; done lands len edges later.
  task automatic serve(input logic [NUM_REQ-1:0] g, input int len, input bit overrun);
    check_val("grant_rise", 32'(bus.grant), 32'(g));
    check_val("draw_start_rise", 32'(bus.draw_start), 32'd1);
    tick();
    check_val("draw_start_fall", 32'(bus.draw_start), 32'd0);
    check_val("grant_hold", 32'(bus.grant), 32'(g));
    for (int i = 0; i < len - 2; i++) begin
      if (overrun) begin
        bus.frame_start = (i < 3);
        if (i == 0) bus.req = 4'b0100;
      end
      tick();
    end
    bus.frame_start = 1'b0;
    finish_draw();
    check_val("grant_gap", 32'(bus.grant), 32'd0);
    tick();
  endtask

  task automatic do_swap();
    check_val("swap_req_high", 32'(bus.swap_req), 32'd1);
    bus.swap_ack = 1'b1;
    tick();
    bus.swap_ack = 1'b0;
    check_val("swap_req_low", 32'(bus.swap_req), 32'd0);
    check_val("frame_done_pulse", 32'(bus.frame_done), 32'd1);
    tick();
    check_val("frame_done_clear", 32'(bus.frame_done), 32'd0);
    check_val("busy_after_swap", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    RESET = 1'b1;
    bus.frame_start = 1'b0;
    bus.req = '0;
    bus.draw_done = 1'b0;
    bus.swap_ack = 1'b0;
    repeat (2) tick();
    check_val("rst_grant", 32'(bus.grant), 32'd0);
    check_val("rst_draw_start", 32'(bus.draw_start), 32'd0);
    check_val("rst_swap_req", 32'(bus.swap_req), 32'd0);
    check_val("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_overrun", 32'(bus.overrun_cnt), 32'd0);
    check_val("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    RESET = 1'b0;
    tick();

    // Normal frame, 3 overrun pulses and a req change during client 0.
    start_frame(4'b1011);
    check_val("arb_busy", 32'(bus.busy), 32'd1);
    check_val("arb_no_grant", 32'(bus.grant), 32'd0);
    tick();
    serve(4'b0001, 10, 1'b1);
    serve(4'b0010, 10, 1'b0);
    serve(4'b1000, 10, 1'b0);
    do_swap();
    check_val("overrun_3", 32'(bus.overrun_cnt), 32'd3);
    check_val("no_timeout_normal", 32'(bus.timeout_err), 32'd0);

    // Empty frame still swaps; stray done ignored; overrun saturates.
    start_frame(4'b0000);
    check_val("empty_busy", 32'(bus.busy), 32'd1);
    check_val("empty_swap_not_yet", 32'(bus.swap_req), 32'd0);
    tick();
    check_val("empty_swap_req", 32'(bus.swap_req), 32'd1);
    check_val("empty_no_grant", 32'(bus.grant), 32'd0);
    finish_draw();
    check_val("done_ignored_swap", 32'(bus.swap_req), 32'd1);
    check_val("done_ignored_busy", 32'(bus.busy), 32'd1);
    bus.frame_start = 1'b1;
    repeat (300) tick();
    bus.frame_start = 1'b0;
    check_val("overrun_sat", 32'(bus.overrun_cnt), 32'd255);
    do_swap();
    check_val("overrun_sat_hold", 32'(bus.overrun_cnt), 32'd255);

    // Watchdog: client 0 silent, client 1 done on the final watchdog cycle.
    start_frame(4'b0011);
    tick();
    check_val("to_grant0", 32'(bus.grant), 32'h1);
    repeat (TIMEOUT - 1) tick();
    check_val("to_hold_last", 32'(bus.grant), 32'h1);
    check_val("to_err_not_yet", 32'(bus.timeout_err), 32'd0);
    tick();
    check_val("to_release", 32'(bus.grant), 32'd0);
    check_val("to_err_set", 32'(bus.timeout_err), 32'h1);
    tick();
    check_val("to_grant1", 32'(bus.grant), 32'h2);
    repeat (TIMEOUT - 1) tick();
    check_val("coinc_hold", 32'(bus.grant), 32'h2);
    finish_draw();
    check_val("coinc_release", 32'(bus.grant), 32'd0);
    check_val("coinc_no_err", 32'(bus.timeout_err), 32'h1);
    tick();
    do_swap();

    // Reset during WAIT, then a fresh schedule from index 0.
    start_frame(4'b0110);
    tick();
    check_val("mid_grant", 32'(bus.grant), 32'h2);
    repeat (4) tick();
    RESET = 1'b1;
    tick();
    check_val("mid_rst_grant", 32'(bus.grant), 32'd0);
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst_tout", 32'(bus.timeout_err), 32'd0);
    check_val("mid_rst_overrun", 32'(bus.overrun_cnt), 32'd0);
    RESET = 1'b0;
    exp_grant_q.delete();
    tick();
    start_frame(4'b0101);
    tick();
    serve(4'b0001, 5, 1'b0);
    serve(4'b0100, 3, 1'b0);
    do_swap();
    check_val("post_rst_tout", 32'(bus.timeout_err), 32'd0);

    check_val("sb_drained", 32'(exp_grant_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
